rx_sfd_detect: RTL

RX_SFD_DETECT -- requirements
Module: rx_sfd_detect

---
 rtl/rx_sfd_detect_pkg.sv | 16 +
 rtl/rx_sfd_detect.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rx_sfd_detect_pkg.sv
// Shared definitions for the MII receive preamble/SFD detector:
// state encoding, framing nibbles and the nibble-count width.
package rx_sfd_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;
  localparam int         CNT_W   = 12;

endpackage

// File: rtl/rx_sfd_detect.sv
// MII receive preamble/SFD detector: strips the preamble, streams frame nibbles
// with an index, and flags framing, length and (with RX_ER_CHECK_EN) rx_er aborts.
module rx_sfd_detect
  import rx_sfd_detect_pkg::*;
#(
  parameter logic [3:0]       MIN_PRE = 4'd7,
  parameter logic [CNT_W-1:0] MAX_NIB = 12'd3036
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_rx_dv,
  input  logic [3:0]       I_rxd,
  input  logic             I_rx_er,
  output logic             O_en_ck,
  output logic [3:0]       O_da_hf,
  output logic [CNT_W-1:0] O_rd_cnt,
  output logic             O_sfd_ok,
  output logic             O_pre_err,
  output logic             O_frm_end,
  output logic             O_len_err
);

  state_t           state_reg;
  logic [3:0]       pre_cnt_reg;
  logic             en_ck_reg;
  logic [3:0]       da_hf_reg;
  logic [CNT_W-1:0] rd_cnt_reg;
  logic             sfd_ok_reg;
  logic             pre_err_reg;
  logic             frm_end_reg;
  logic             len_err_reg;

  logic             rx_er_hit;
  logic [CNT_W-1:0] nib_idx;

`ifdef RX_ER_CHECK_EN
  assign rx_er_hit = I_rx_er;
`else
  logic unused_rx_er;
  assign rx_er_hit    = 1'b0;
  assign unused_rx_er = I_rx_er;
`endif

  // Index of the nibble on I_rxd: en_ck is low only before the first data nibble.
  assign nib_idx = en_ck_reg ? (rd_cnt_reg + CNT_W'(1)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pre_cnt_reg <= '0;
      en_ck_reg   <= 1'b0;
      da_hf_reg   <= '0;
      rd_cnt_reg  <= '0;
      sfd_ok_reg  <= 1'b0;
      pre_err_reg <= 1'b0;
      frm_end_reg <= 1'b0;
      len_err_reg <= 1'b0;
    end else begin
      sfd_ok_reg  <= 1'b0;
      pre_err_reg <= 1'b0;
      frm_end_reg <= 1'b0;
      len_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          en_ck_reg   <= 1'b0;
          da_hf_reg   <= '0;
          rd_cnt_reg  <= '0;
          pre_cnt_reg <= '0;
          if (I_rx_dv) begin
            if (I_rxd == PRE_NIB) begin
              state_reg   <= ST_PRE;
              pre_cnt_reg <= 4'd1;
            end else begin
              state_reg   <= ST_DROP;
              pre_err_reg <= 1'b1;
            end
          end
        end
        ST_PRE: begin
          en_ck_reg  <= 1'b0;
          da_hf_reg  <= '0;
          rd_cnt_reg <= '0;
          if (!I_rx_dv) begin
            state_reg   <= ST_IDLE;
            pre_cnt_reg <= '0;
            pre_err_reg <= 1'b1;
          end else if (rx_er_hit) begin
            state_reg   <= ST_DROP;
            pre_cnt_reg <= '0;
            pre_err_reg <= 1'b1;
          end else if (I_rxd == PRE_NIB) begin
            if (pre_cnt_reg != 4'hF) begin
              pre_cnt_reg <= pre_cnt_reg + 4'd1;
            end
          end else if ((I_rxd == SFD_NIB) && (pre_cnt_reg >= MIN_PRE)) begin
            state_reg   <= ST_DATA;
            pre_cnt_reg <= '0;
            sfd_ok_reg  <= 1'b1;
          end else begin
            state_reg   <= ST_DROP;
            pre_cnt_reg <= '0;
            pre_err_reg <= 1'b1;
          end
        end
        ST_DATA: begin
          pre_cnt_reg <= '0;
          if (!I_rx_dv) begin
            state_reg   <= ST_IDLE;
            en_ck_reg   <= 1'b0;
            da_hf_reg   <= '0;
            rd_cnt_reg  <= '0;
            frm_end_reg <= 1'b1;
          end else if (rx_er_hit) begin
            state_reg   <= ST_DROP;
            en_ck_reg   <= 1'b0;
            da_hf_reg   <= '0;
            rd_cnt_reg  <= '0;
            len_err_reg <= 1'b1;
          end else begin
            en_ck_reg  <= 1'b1;
            da_hf_reg  <= I_rxd;
            rd_cnt_reg <= nib_idx;
            // Last allowed nibble is still delivered; the frame is cut after it.
            if (nib_idx == (MAX_NIB - CNT_W'(1))) begin
              state_reg   <= ST_DROP;
              len_err_reg <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          en_ck_reg   <= 1'b0;
          da_hf_reg   <= '0;
          rd_cnt_reg  <= '0;
          pre_cnt_reg <= '0;
          if (!I_rx_dv) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          en_ck_reg   <= 1'b0;
          da_hf_reg   <= '0;
          rd_cnt_reg  <= '0;
          pre_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign O_en_ck   = en_ck_reg;
  assign O_da_hf   = da_hf_reg;
  assign O_rd_cnt  = rd_cnt_reg;
  assign O_sfd_ok  = sfd_ok_reg;
  assign O_pre_err = pre_err_reg;
  assign O_frm_end = frm_end_reg;
  assign O_len_err = len_err_reg;

endmodule
